ram_param: RTL and testbench
============================

# ram_param

Parametrised single-port synchronous RAM, the next generation of the fixed 64 × 16 memory. Width and depth are generic. Reads are registered with a fixed one-cycle latency, and a selectable read-during-write mode sets what a same-address read returns. A built-in clear sequencer zeroes the array after reset or on request. The block is the memory primitive for the register-file and data-memory levels above it.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 64, number of words (≥2; need not be a power of two)
- `ADDR_W`, `$clog2(DEPTH)`, address width
- `RDW_MODE`, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data)

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `load`  in  1  write enable
- `address`  in  ADDR_W  read/write address
- `in`  in  WIDTH  write data
- `clr`  in  1  one-cycle request to zero the whole array
- `out`  out  WIDTH  registered read data
- `busy`  out  1  clear sequencer active; user accesses ignored

## Operation
- The array has no reset. The clear sequencer is its only initialiser.
- FSM states:
  - CLEAR: writes 0 to `clr_addr`, then increments `clr_addr`. Moves to IDLE on the edge that writes `DEPTH-1`.
  - IDLE: serves user accesses. `clr` high moves to CLEAR with `clr_addr` = 0.
- Reset (`rst_n` low): state = CLEAR, `clr_addr` = 0, `out` = 0, `busy` = 1.
- IDLE write: `load` = 1 writes `mem[address] <= in` on the edge.
- IDLE read: every edge, `out <= mem[address]`, whether or not `load` is set.
- Read-during-write to the same address:
  - `RDW_MODE` = 0: `out` gets the pre-write contents.
  - `RDW_MODE` = 1: `out` gets `in`.
- CLEAR state:
  - `load` is ignored and no user write occurs.
  - `out` is forced to 0 each edge.
  - `clr` is ignored; no restart.
- `clr` and `load` high together in IDLE: `clr` wins. The write is dropped; `out` still captures `mem[address]` on that edge.
- Out-of-range address (`address` ≥ `DEPTH`): write ignored, read returns 0.
- Reset asserted mid-clear: sequencer restarts from address 0 after release. Partially cleared contents are don't-care because a full clear follows.

## Timing
- Read latency is 1 cycle: address presented before edge N, data on `out` after edge N.
- Write takes effect at edge N and is visible to a read registered at edge N+1 (or at edge N in write-first mode).
- Clear after reset release:
  - The first rising edge after `rst_n` rises writes location 0.
  - `busy` stays 1 for exactly `DEPTH` edges and drops after the edge that writes `DEPTH-1`.
  - The first user access is accepted at edge `DEPTH`+1.
- Clear on request:
  - `clr` sampled at edge N moves the FSM to CLEAR and raises `busy` after edge N.
  - Locations 0 … `DEPTH-1` are written at edges N+1 … N+`DEPTH`.
  - `busy` falls after edge N+`DEPTH`.
- `busy` is a registered output, decoded directly from state with no combinational path from inputs.
- `clr_addr` wraps only through the IDLE transition and never exceeds `DEPTH-1`.

## Structure
- Shared package `ram_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_CLEAR`)
  - the `RDW_MODE` constants `RDW_READ_FIRST` = 0 and `RDW_WRITE_FIRST` = 1
  - a `ram_addr_w(depth)` helper function
- One sub-module, `ram_clear_seq`, contains the FSM and the `clr_addr` counter. Its outputs are `busy`, `clr_we` and `clr_addr`.
- The top level holds the array, the write-port mux (sequencer vs. user), the read register and the RDW mode select.

## Test plan
- **Reset clear (`DEPTH`=64, `WIDTH`=16):** release `rst_n`.
  - `busy` = 1 for exactly 64 edges, then 0.
  - Reading addresses 0, 31 and 63 returns `0x0000`.
- **Basic write/read:**
  - Write `0xBEEF` at 5 and `0x1234` at 63; read 5 then 63.
  - `out` = `0xBEEF`, then `0x1234`, each one cycle after its address.
- **Read-during-write:**
  - Preload address 9 with `0x00AA`, then write `0x0055` at 9 with `load` = 1.
  - `RDW_MODE` = 0: `out` = `0x00AA`. `RDW_MODE` = 1: `out` = `0x0055`.
  - Both modes: the next read returns `0x0055`.
- **Clear on request with collision:**
  - Fill all 64 words with their index, then pulse `clr` together with `load` writing `0xFFFF` at 3.
  - Write is dropped; `busy` is high for 64 edges; all words read 0.
  - `load` during `busy` writes nothing.
- **Reset mid-clear:**
  - Pulse `clr`, then assert `rst_n` low at clear edge 20.
  - `out` = 0 and `busy` = 1 immediately.
  - After release, 64 more `busy` edges, then the array reads all zero.
- **Non-power-of-two (`DEPTH`=48, `WIDTH`=8):**
  - `busy` lasts 48 edges.
  - Writing `0x7F` at address 50 is ignored, and reading 50 returns `0x00`.
  - Address 47 writes and reads back `0x7F`.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised single-port RAM family.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Address width for a given depth; a one-word array still needs one bit.
    function automatic int ram_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every location once after reset or on a clr request.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = ram_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
        // busy follows the next state so it is a flop, not decode of the inputs.
        busy_d = (state_d == ST_CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous RAM with registered read, selectable
// read-during-write behaviour and a built-in clear sequencer.
module ram_param
    import ram_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = ram_addr_w(DEPTH),
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              in_range;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  out_q, out_d;

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A clr request in the same cycle as load drops the user write.
    always_comb begin
        in_range = ({1'b0, address} < DEPTH_EXT);
        user_we  = !clr_we && load && !clr && in_range;
        wr_en    = clr_we || user_we;
        wr_addr  = clr_we ? clr_addr : address;
        wr_data  = clr_we ? '0 : in;
        rd_data  = in_range ? mem[address] : '0;
    end

    // NOTE: the array carries no reset; the clear sequencer is its only initialiser.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        out_d = rd_data;
        if (clr_we) begin
            out_d = '0;
        end else if ((RDW_MODE == RDW_WRITE_FIRST) && user_we) begin
            out_d = in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_ram_param.sv
// Self-checking bench: three RAM configurations share one stimulus stream and
// are compared every cycle against an array-based reference model.
module tb_ram_param;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        clr;
    logic [5:0]  address;
    logic [15:0] din;
    logic [15:0] out_rf, out_wf;
    logic [7:0]  out_sm;
    logic        busy_rf, busy_wf, busy_sm;

    ram_param #(.WIDTH(16), .DEPTH(64), .RDW_MODE(0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .load(load), .address(address),
        .in(din), .clr(clr), .out(out_rf), .busy(busy_rf)
    );

    ram_param #(.WIDTH(16), .DEPTH(64), .RDW_MODE(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .load(load), .address(address),
        .in(din), .clr(clr), .out(out_wf), .busy(busy_wf)
    );

    ram_param #(.WIDTH(8), .DEPTH(48), .RDW_MODE(0)) dut_sm (
        .clk(clk), .rst_n(rst_n), .load(load), .address(address),
        .in(din[7:0]), .clr(clr), .out(out_sm), .busy(busy_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents, remaining clear edges and expected read data.
    logic [15:0] m64 [64];
    logic [7:0]  m48 [48];
    int          left64, left48;
    logic [15:0] exp_rf, exp_wf;
    logic [7:0]  exp_sm;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        left64 = 64;
        left48 = 48;
        exp_rf = '0;
        exp_wf = '0;
        exp_sm = '0;
    endtask

    task automatic model_edge(input logic l, input logic c, input logic [5:0] a, input logic [15:0] d);
        logic [15:0] old16;
        logic [7:0]  old8;
        if (left64 > 0) begin
            m64[64 - left64] = '0;
            left64--;
            exp_rf = '0;
            exp_wf = '0;
        end else begin
            old16  = m64[a];
            exp_rf = old16;
            exp_wf = (l && !c) ? d : old16;
            if (c) left64 = 64;
            else if (l) m64[a] = d;
        end
        if (left48 > 0) begin
            m48[48 - left48] = '0;
            left48--;
            exp_sm = '0;
        end else begin
            old8 = (a < 48) ? m48[a] : 8'h00;
            exp_sm = old8;
            if (c) left48 = 48;
            else if (l && a < 48) m48[a] = d[7:0];
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ".out_rf"},  32'(out_rf),  32'(exp_rf));
        check({phase, ".out_wf"},  32'(out_wf),  32'(exp_wf));
        check({phase, ".out_sm"},  32'(out_sm),  32'(exp_sm));
        check({phase, ".busy_rf"}, 32'(busy_rf), 32'(left64 > 0));
        check({phase, ".busy_wf"}, 32'(busy_wf), 32'(left64 > 0));
        check({phase, ".busy_sm"}, 32'(busy_sm), 32'(left48 > 0));
    endtask

    // One clock: drive inputs, let the edge pass, update the model, sample.
    task automatic cyc(input string phase, input logic l, input logic c,
                       input logic [5:0] a, input logic [15:0] d);
        load    = l;
        clr     = c;
        address = a;
        din     = d;
        @(posedge clk);
        model_edge(l, c, a, d);
        #1;
        check_all(phase);
    endtask

    task automatic idle_cycles(input string phase, input int n);
        for (int i = 0; i < n; i++) cyc(phase, 1'b0, 1'b0, 6'd0, 16'h0);
    endtask

    task automatic read_all(input string phase);
        for (int i = 0; i < 64; i++) cyc(phase, 1'b0, 1'b0, 6'(i), 16'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
        address = '0;
        din     = '0;
        model_reset();

        #12;
        check_all("reset");
        #1 rst_n = 1'b1;

        // Power-up clear: busy for 64 (resp. 48) edges, then zeros everywhere.
        idle_cycles("init_clear", 65);
        cyc("rd_zero0",  1'b0, 1'b0, 6'd0,  16'h0);
        cyc("rd_zero31", 1'b0, 1'b0, 6'd31, 16'h0);
        cyc("rd_zero63", 1'b0, 1'b0, 6'd63, 16'h0);

        cyc("wr5",   1'b1, 1'b0, 6'd5,  16'hBEEF);
        cyc("wr63",  1'b1, 1'b0, 6'd63, 16'h1234);
        cyc("rd5",   1'b0, 1'b0, 6'd5,  16'h0);
        cyc("rd63",  1'b0, 1'b0, 6'd63, 16'h0);
        check("rd63_direct_rf", 32'(out_rf), 32'h1234);

        // Read-during-write at address 9.
        cyc("pre9",  1'b1, 1'b0, 6'd9, 16'h00AA);
        cyc("rdw9",  1'b1, 1'b0, 6'd9, 16'h0055);
        check("rdw_read_first",  32'(out_rf), 32'h00AA);
        check("rdw_write_first", 32'(out_wf), 32'h0055);
        cyc("after_rdw9", 1'b0, 1'b0, 6'd9, 16'h0);
        check("after_rdw_rf", 32'(out_rf), 32'h0055);

        // Fill with index, then clr colliding with a write.
        for (int i = 0; i < 64; i++) cyc("fill", 1'b1, 1'b0, 6'(i), 16'(i));
        cyc("clr_collide", 1'b1, 1'b1, 6'd3, 16'hFFFF);
        for (int i = 0; i < 64; i++)
            cyc("load_in_clear", 1'b1, 1'b0, 6'($urandom_range(0, 63)), 16'($urandom));
        read_all("rd_after_clr");

        // Reset in the middle of a requested clear.
        for (int i = 0; i < 64; i++) cyc("fill2", 1'b1, 1'b0, 6'(i), 16'hA500 + 16'(i));
        cyc("clr_req", 1'b0, 1'b1, 6'd0, 16'h0);
        idle_cycles("mid_clear", 19);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #1 rst_n = 1'b1;
        idle_cycles("reclear", 64);
        read_all("rd_after_reclear");

        // Out-of-range and top-address behaviour of the 48-deep instance.
        cyc("wr50", 1'b1, 1'b0, 6'd50, 16'h007F);
        cyc("wr47", 1'b1, 1'b0, 6'd47, 16'h007F);
        cyc("rd50", 1'b0, 1'b0, 6'd50, 16'h0);
        check("rd50_sm", 32'(out_sm), 32'h00);
        cyc("rd47", 1'b0, 1'b0, 6'd47, 16'h0);
        check("rd47_sm", 32'(out_sm), 32'h7F);

        // Random traffic with occasional clear requests.
        for (int i = 0; i < 500; i++)
            cyc("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 79) == 0),
                6'($urandom_range(0, 63)), 16'($urandom));
        idle_cycles("drain", 65);
        read_all("rd_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
